// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch defaults and the fetch control state type.
// No ports; imported by the instruction fetch RTL.
package cpu_pkg;

  localparam int PCLEN_DEF  = 16;
  localparam int IWIDTH_DEF = 32;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: imem req/gnt/rvalid bus plus decode valid/ready bus.
// master = fetch unit; slave = memory and decode side.
interface instr_fetch_if #(
  parameter int PCLEN  = cpu_pkg::PCLEN_DEF,
  parameter int IWIDTH = cpu_pkg::IWIDTH_DEF
);

  logic              imem_req;
  logic [PCLEN-1:0]  imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [IWIDTH-1:0] imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [IWIDTH-1:0] instr;
  logic [PCLEN-1:0]  instr_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: in-order {pc, instr, filled} slots with alloc/fill/rd pointers.
// Ports: alloc (pc), fill (instr), pop, flush; outputs count and head slot.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int PCLEN  = PCLEN_DEF,
  parameter int IWIDTH = IWIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              alloc_i,
  input  logic [PCLEN-1:0]  alloc_pc_i,
  input  logic              fill_i,
  input  logic [IWIDTH-1:0] fill_instr_i,
  input  logic              pop_i,
  output logic [CW-1:0]     count_o,
  output logic              head_valid_o,
  output logic [IWIDTH-1:0] head_instr_o,
  output logic [PCLEN-1:0]  head_pc_o
);

  logic [PCLEN-1:0]  pc_q    [DEPTH];
  logic [IWIDTH-1:0] instr_q [DEPTH];
  logic [DEPTH-1:0]  filled_q;
  logic [DEPTH-1:0]  filled_d;
  logic [AW-1:0]     alloc_q;
  logic [AW-1:0]     fill_q;
  logic [AW-1:0]     rd_q;
  logic [CW-1:0]     count_q;

  // fill always targets an allocated, unfilled slot, so it never
  // collides with the filled head being popped.
  always_comb begin
    filled_d = filled_q;
    if (pop_i)  filled_d[rd_q]   = 1'b0;
    if (fill_i) filled_d[fill_q] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
      filled_q <= '0;
      alloc_q  <= '0;
      fill_q   <= '0;
      rd_q     <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      filled_q <= '0;
      alloc_q  <= '0;
      fill_q   <= '0;
      rd_q     <= '0;
      count_q  <= '0;
    end else begin
      if (alloc_i) begin
        pc_q[alloc_q] <= alloc_pc_i;
        alloc_q       <= alloc_q + 1'b1;
      end
      if (fill_i) begin
        instr_q[fill_q] <= fill_instr_i;
        fill_q          <= fill_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
      filled_q <= filled_d;
      count_q  <= count_q + CW'(alloc_i) - CW'(pop_i);
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = filled_q[rd_q];
  assign head_instr_o = instr_q[rd_q];
  assign head_pc_o    = pc_q[rd_q];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch PC stream, imem requests with credit and drop control.
// Ports: clock, reset, redirect/redirect_pc, bus (imem + decode handshakes).
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int PCLEN  = PCLEN_DEF,
  parameter int IWIDTH = IWIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             redirect,
  input  logic [PCLEN-1:0] redirect_pc,
  instr_fetch_if.master    bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_t     state_q;
  logic [PCLEN-1:0] fptr_q;
  logic [CW-1:0]    outst_q;
  logic [CW-1:0]    outst_d;
  logic [CW-1:0]    drop_q;
  logic [CW-1:0]    drop_d;
  logic [CW-1:0]    count;
  logic             req;
  logic             grant;
  logic             rsp;
  logic             keep;
  logic             consume;
  logic             head_valid;
  logic [IWIDTH-1:0] head_instr;
  logic [PCLEN-1:0] head_pc;

  // reset gates req so the request drops the instant reset asserts
  assign req     = ~reset & ~redirect
                 & (count < FULL) & (outst_q < FULL);
  assign grant   = req & bus.imem_gnt;
  assign rsp     = bus.imem_rvalid;
  assign keep    = rsp & (state_q == RUN) & ~redirect;
  assign consume = head_valid & bus.instr_ready;
  assign outst_d = outst_q + CW'(grant) - CW'(rsp);

  // on redirect everything still in flight after this cycle is stale
  always_comb begin
    drop_d = drop_q;
    if (redirect)
      drop_d = outst_d;
    else if (rsp && drop_q != '0)
      drop_d = drop_q - 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      fptr_q  <= '0;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      outst_q <= outst_d;
      drop_q  <= drop_d;
      if (redirect)
        fptr_q <= redirect_pc;
      else if (grant)
        fptr_q <= fptr_q + 1'b1;
      unique case (state_q)
        RUN:     if (drop_d != '0) state_q <= FLUSH;
        FLUSH:   if (drop_d == '0) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  fetch_queue #(
    .PCLEN  (PCLEN),
    .IWIDTH (IWIDTH),
    .DEPTH  (DEPTH)
  ) u_queue (
    .clock        (clock),
    .reset        (reset),
    .flush_i      (redirect),
    .alloc_i      (grant),
    .alloc_pc_i   (fptr_q),
    .fill_i       (keep),
    .fill_instr_i (bus.imem_rdata),
    .pop_i        (consume),
    .count_o      (count),
    .head_valid_o (head_valid),
    .head_instr_o (head_instr),
    .head_pc_o    (head_pc)
  );

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fptr_q;
  assign bus.instr_valid = head_valid;
  assign bus.instr       = head_instr;
  assign bus.instr_pc    = head_pc;

endmodule
